// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the write-back stage: special-register addresses
// in the low file page and the STATUS flag bit positions.
package alu_writeback_pkg;

    // Low-page special register addresses (ea[4:3] == 0).
    typedef enum logic [2:0] {
        ADDR_INDF   = 3'd0,
        ADDR_RTCC   = 3'd1,
        ADDR_PCL    = 3'd2,
        ADDR_STATUS = 3'd3,
        ADDR_FSR    = 3'd4,
        ADDR_PORTA  = 3'd5,
        ADDR_PORTB  = 3'd6,
        ADDR_PORTC  = 3'd7
    } spec_addr_e;

    // STATUS flag positions; bits [7:3] are general purpose.
    localparam int ST_C  = 0;
    localparam int ST_DC = 1;
    localparam int ST_Z  = 2;

endpackage

// File: rtl/alu_writeback_status_merge.sv
// Next-STATUS computation: a file write loads the whole byte, then each
// enabled ALU flag update overrides its own bit on the same edge.
module status_merge
    import alu_writeback_pkg::*;
(
    input  logic [7:0] status_i,
    input  logic       file_we_i,
    input  logic [7:0] file_data_i,
    input  logic       c_we_i,
    input  logic       c_i,
    input  logic       dc_we_i,
    input  logic       dc_i,
    input  logic       z_we_i,
    input  logic       z_i,
    output logic [7:0] status_o
);

    // Flag updates take priority over the file-write byte.
    always_comb begin
        status_o = file_we_i ? file_data_i : status_i;
        if (c_we_i)  status_o[ST_C]  = c_i;
        if (dc_we_i) status_o[ST_DC] = dc_i;
        if (z_we_i)  status_o[ST_Z]  = z_i;
    end

endmodule

// File: rtl/alu_writeback.sv
// Write-back stage of the 8-bit datapath. Commits the ALU result to W, the
// special registers or the register file / PCL / RTCC via one-cycle strobes.
// Build option: ALU_WB_INDIRECT_EN enables INDF (fsel == 0) resolution
// through FSR; without it fsel == 0 writes are dropped.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int          RF_AW    = 5,
    parameter logic [7:0]  TRIS_RST = 8'hFF
) (
    input  logic             clk2,
    input  logic             reset,
    input  logic             en,
    input  logic [7:0]       aluout,
    input  logic [RF_AW-1:0] fsel,
    input  logic             fwe,
    input  logic             wwe,
    input  logic             tris_we,
    input  logic             option_we,
    input  logic             alu_c,
    input  logic             alu_dc,
    input  logic             alu_z,
    input  logic             c_we,
    input  logic             dc_we,
    input  logic             z_we,
    output logic [7:0]       w,
    output logic [7:0]       fsr,
    output logic [7:0]       status,
    output logic [7:0]       option,
    output logic [7:0]       porta,
    output logic [7:0]       portb,
    output logic [7:0]       portc,
    output logic [7:0]       trisa,
    output logic [7:0]       trisb,
    output logic [7:0]       trisc,
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_addr,
    output logic [7:0]       rf_wdata,
    output logic             pc_we,
    output logic             rtcc_we,
    output logic [7:0]       spec_wdata
);

    logic [7:0]       w_q, fsr_q, status_q, option_q;
    logic [7:0]       porta_q, portb_q, portc_q;
    logic [7:0]       trisa_q, trisb_q, trisc_q;
    logic             rf_we_q, pc_we_q, rtcc_we_q;
    logic [RF_AW-1:0] rf_addr_q;
    logic [7:0]       rf_wdata_q, spec_wdata_q;

    logic [RF_AW-1:0] ea;
    logic             rf_hit;
    logic             wr_rtcc, wr_pcl, wr_status, wr_fsr;
    logic             wr_porta, wr_portb, wr_portc;
    logic [7:0]       status_d;

    // Effective address and destination decode for an accepted file write.
    always_comb begin
        ea = fsel;
`ifdef ALU_WB_INDIRECT_EN
        if (fsel == '0) ea = fsr_q[RF_AW-1:0];
`endif
        rf_hit    = en && fwe && (ea[RF_AW-1:3] != '0);
        wr_rtcc   = 1'b0;
        wr_pcl    = 1'b0;
        wr_status = 1'b0;
        wr_fsr    = 1'b0;
        wr_porta  = 1'b0;
        wr_portb  = 1'b0;
        wr_portc  = 1'b0;
        if (en && fwe && !rf_hit) begin
            case (spec_addr_e'(ea[2:0]))
                ADDR_RTCC:   wr_rtcc   = 1'b1;
                ADDR_PCL:    wr_pcl    = 1'b1;
                ADDR_STATUS: wr_status = 1'b1;
                ADDR_FSR:    wr_fsr    = 1'b1;
                ADDR_PORTA:  wr_porta  = 1'b1;
                ADDR_PORTB:  wr_portb  = 1'b1;
                ADDR_PORTC:  wr_portc  = 1'b1;
                default:     ;  // INDF through INDF: write dropped
            endcase
        end
    end

    status_merge u_status_merge (
        .status_i    (status_q),
        .file_we_i   (wr_status),
        .file_data_i (aluout),
        .c_we_i      (c_we),
        .c_i         (alu_c),
        .dc_we_i     (dc_we),
        .dc_i        (alu_dc),
        .z_we_i      (z_we),
        .z_i         (alu_z),
        .status_o    (status_d)
    );

    // Architectural registers; everything holds while en is low.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            w_q      <= 8'h00;
            fsr_q    <= 8'h00;
            status_q <= 8'h00;
            porta_q  <= 8'h00;
            portb_q  <= 8'h00;
            portc_q  <= 8'h00;
            trisa_q  <= TRIS_RST;
            trisb_q  <= TRIS_RST;
            trisc_q  <= TRIS_RST;
            option_q <= TRIS_RST;
        end else if (en) begin
            if (wwe)      w_q     <= aluout;
            if (wr_fsr)   fsr_q   <= aluout;
            if (wr_porta) porta_q <= aluout;
            if (wr_portb) portb_q <= aluout;
            if (wr_portc) portc_q <= aluout;
            status_q <= status_d;
            // TRIS/OPTION are loaded from the pre-edge W, not the ALU result.
            if (tris_we) begin
                case (spec_addr_e'(fsel[2:0]))
                    ADDR_PORTA: trisa_q <= w_q;
                    ADDR_PORTB: trisb_q <= w_q;
                    ADDR_PORTC: trisc_q <= w_q;
                    default:    ;
                endcase
            end
            if (option_we) option_q <= w_q;
        end
    end

    // One-cycle write strobes; address/data hold after the pulse.
    always_ff @(posedge clk2 or posedge reset) begin
        if (reset) begin
            rf_we_q      <= 1'b0;
            pc_we_q      <= 1'b0;
            rtcc_we_q    <= 1'b0;
            rf_addr_q    <= '0;
            rf_wdata_q   <= 8'h00;
            spec_wdata_q <= 8'h00;
        end else begin
            rf_we_q   <= rf_hit;
            pc_we_q   <= wr_pcl;
            rtcc_we_q <= wr_rtcc;
            if (rf_hit) begin
                rf_addr_q  <= ea;
                rf_wdata_q <= aluout;
            end
            if (wr_pcl || wr_rtcc) spec_wdata_q <= aluout;
        end
    end

    assign w          = w_q;
    assign fsr        = fsr_q;
    assign status     = status_q;
    assign option     = option_q;
    assign porta      = porta_q;
    assign portb      = portb_q;
    assign portc      = portc_q;
    assign trisa      = trisa_q;
    assign trisb      = trisb_q;
    assign trisc      = trisc_q;
    assign rf_we      = rf_we_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pc_we      = pc_we_q;
    assign rtcc_we    = rtcc_we_q;
    assign spec_wdata = spec_wdata_q;

endmodule
